uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Hardware transmit sequencer and bus arbiter for the UART peripheral. It holds a 16-byte message buffer. On a start pulse it autonomously polls the UART status register and writes each character to the TX data register. While a message is in flight, it blocks the execute stage's memory-port accesses to the UART region. It sits between the ex-stage UART-decoded memory request and the UART peripheral bus slave.

## Interface
Parameters:
- UART_STATUS_ADDR, 32'h30000004, status register; bit0 = 1 means TX busy
- UART_TXDATA_ADDR, 32'h30000008, TX data register; low byte transmitted
- BUF_DEPTH, 16, message buffer entries (8 bit each)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start_i  in  1  pulse: begin transmitting buf[0..len_i-1]
- len_i  in  5  message length, sampled with start_i; values above BUF_DEPTH saturate to BUF_DEPTH
- abort_i  in  1  cancel the current message
- buf_we_i  in  1  message buffer write strobe
- buf_addr_i  in  4  buffer write index
- buf_data_i  in  8  buffer write data
- cpu_req_i  in  1  ex-stage UART-region access request
- cpu_we_i  in  1  ex-stage write flag
- cpu_addr_i  in  32  ex-stage address
- cpu_wdata_i  in  32  ex-stage write data
- cpu_rdata_o  out  32  read data to ex stage; 0 when not granted
- cpu_gnt_o  out  1  access granted this cycle; 0 means the ex stage must hold its request
- bus_req_o, bus_we_o  out  1 each  UART bus request and write flag
- bus_addr_o, bus_wdata_o  out  32 each  UART bus address and write data
- bus_rdata_i  in  32  UART bus read data, combinational, same cycle as request
- busy_o  out  1  message in flight
- done_o  out  1  one-cycle pulse: message completed normally
- sent_cnt_o  out  5  characters written for the current or last message

## Operation
- States are IDLE, POLL, WRITE, HOLD and DONE. Reset puts the block in IDLE.
- Reset values: all outputs 0, index 0, length 0. Buffer contents are not reset.
- **IDLE:**
  - The CPU path is passed through: bus_* = cpu_*, cpu_rdata_o = bus_rdata_i, cpu_gnt_o = cpu_req_i.
  - start_i with a saturated length of 0: go to DONE.
  - start_i otherwise: latch the length, clear the index and sent_cnt_o, go to POLL.
  - If a CPU access is present in the same cycle as start_i, the CPU access completes in that cycle.
- **POLL:**
  - Drive a read of UART_STATUS_ADDR.
  - bus_rdata_i[0] == 0: go to WRITE. Otherwise stay in POLL.
- **WRITE:**
  - Drive a write of UART_TXDATA_ADDR with {24'b0, buf[index]}.
  - Increment the index and sent_cnt_o.
  - Go to DONE if the new index equals the length, otherwise go to HOLD.
- **HOLD:** no bus request; gives the UART one cycle to raise its busy bit. Go to POLL.
- **DONE:** done_o = 1, busy_o = 0, CPU path passed through as in IDLE. Go to IDLE.
- busy_o = 1 in POLL, WRITE and HOLD only.
- CPU access while busy_o = 1: cpu_gnt_o = 0 and cpu_rdata_o = 0; the CPU request never reaches the bus.
- start_i is ignored while busy_o = 1 and in DONE.
- buf_we_i writes the buffer in IDLE and DONE; it is ignored while busy_o = 1.
- abort_i: from POLL, WRITE or HOLD, go to IDLE at the next edge with no done_o.
  - abort_i has priority over the WRITE transition, but a write driven in the abort cycle still occurs on the bus.
  - sent_cnt_o retains the count of characters written.
- Reset asserted mid-message: immediate return to IDLE; the UART may have received a partial message.

## Timing
- start_i sampled at edge t: busy_o = 1 and POLL from cycle t+1.
- Character k is written in cycle t+3k+2 when the UART reports idle at every poll.
- Message of N characters with an always-idle UART: done_o in cycle t+3N, busy_o falls in the same cycle.
- Each poll cycle that sees busy adds one cycle; there is no timeout.
- Bus outputs are combinational from state and index (no pipeline stage); bus_rdata_i is consumed in the same cycle.
- Maximum CPU stall equals the message duration.

## Test plan
- Buffer "2023211013" (0x32,0x30,0x32,0x33,0x32,0x31,0x31,0x30,0x31,0x33), len_i = 10, bus_rdata_i[0] held 0 -> exactly 10 writes to 0x30000008, in order, at cycles t+2, t+5, ..., t+29; done_o single pulse at t+30; sent_cnt_o = 10.
- Same message, with the UART model holding status bit0 = 1 for 5 cycles after each write -> every WRITE is preceded by polls until bit0 = 0; byte order unchanged; no write issued while bit0 = 1.
- cpu_req_i = 1 (read of 0x30000004) during a message -> cpu_gnt_o = 0 and cpu_rdata_o = 0 until done_o; CPU read granted in the done_o cycle. start_i and cpu_req_i together in IDLE -> CPU granted that cycle, POLL next cycle.
- len_i = 0 -> no bus activity, done_o at t+1. len_i = 20 -> 16 characters sent, sent_cnt_o = 16.
- abort_i asserted in the HOLD state after the 3rd character -> IDLE next edge, no done_o, sent_cnt_o = 3. A new start_i then sends from buf[0].
- rst pulled low during POLL -> busy_o, done_o, cpu_gnt_o and bus_req_o all 0 immediately without a clock edge; after release, IDLE pass-through works; buf_we_i while busy_o = 1 leaves the buffer contents unchanged.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Execute-stage UART request port and UART peripheral bus port seen by the transmit sequencer.
// The master modport is the sequencer's view; slave is the CPU/UART environment.
interface uart_tx_sched_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_gnt;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_gnt,
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_gnt,
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/uart_tx_sched.sv
// UART transmit sequencer: streams a 16-byte message buffer to the TX data register,
// polling the status register before each character and stalling CPU UART accesses meanwhile.
module uart_tx_sched #(
  parameter logic [31:0] UART_STATUS_ADDR = 32'h3000_0004,
  parameter logic [31:0] UART_TXDATA_ADDR = 32'h3000_0008,
  parameter int          BUF_DEPTH        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [4:0] len_i,
  input  logic       abort_i,
  input  logic       buf_we_i,
  input  logic [3:0] buf_addr_i,
  input  logic [7:0] buf_data_i,
  uart_tx_sched_if.master io,
  output logic       busy_o,
  output logic       done_o,
  output logic [4:0] sent_cnt_o
);

  localparam logic [4:0] DEPTH = 5'(BUF_DEPTH);

  typedef enum logic [2:0] {IDLE, POLL, WRITE, HOLD, DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] len_q, len_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] len_sat;
  logic       pass_through;
  logic [7:0] buf_q [BUF_DEPTH];

  assign busy_o     = (state_q == POLL) || (state_q == WRITE) || (state_q == HOLD);
  assign done_o     = (state_q == DONE);
  assign sent_cnt_o = cnt_q;

  // The message buffer is frozen while a message is in flight.
  always_ff @(posedge clk) begin
    if (buf_we_i && !busy_o) begin
      buf_q[buf_addr_i] <= buf_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    len_sat      = (len_i > DEPTH) ? DEPTH : len_i;
    io.bus_req   = 1'b0;
    io.bus_we    = 1'b0;
    io.bus_addr  = '0;
    io.bus_wdata = '0;
    io.cpu_gnt   = 1'b0;
    io.cpu_rdata = '0;

    // Gating with rst keeps every output low while reset is held.
    pass_through = rst && ((state_q == IDLE) || (state_q == DONE));
    if (pass_through) begin
      io.bus_req   = io.cpu_req;
      io.bus_we    = io.cpu_we;
      io.bus_addr  = io.cpu_addr;
      io.bus_wdata = io.cpu_wdata;
      io.cpu_gnt   = io.cpu_req;
      io.cpu_rdata = io.cpu_req ? io.bus_rdata : '0;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_sat == 5'd0) begin
            state_d = DONE;
          end else begin
            len_d   = len_sat;
            cnt_d   = '0;
            state_d = POLL;
          end
        end
      end
      POLL: begin
        io.bus_req  = 1'b1;
        io.bus_addr = UART_STATUS_ADDR;
        if (!io.bus_rdata[0]) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        io.bus_req   = 1'b1;
        io.bus_we    = 1'b1;
        io.bus_addr  = UART_TXDATA_ADDR;
        io.bus_wdata = {24'b0, buf_q[cnt_q[3:0]]};
        cnt_d        = cnt_q + 5'd1;
        state_d      = (cnt_d == len_q) ? DONE : HOLD;
      end
      HOLD:    state_d = POLL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A write driven in the abort cycle still reaches the UART and is counted.
    if (abort_i && busy_o) begin
      state_d = IDLE;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched with a small UART status/TX model.
module tb_uart_tx_sched;
  localparam logic [31:0] STATUS = 32'h3000_0004;
  localparam logic [31:0] TXDATA = 32'h3000_0008;
  localparam logic [31:0] RD_HI  = 32'hA5A5_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [4:0] len_i = '0;
  logic       abort_i = 1'b0;
  logic       buf_we_i = 1'b0;
  logic [3:0] buf_addr_i = '0;
  logic [7:0] buf_data_i = '0;
  logic       busy_o, done_o;
  logic [4:0] sent_cnt_o;

  uart_tx_sched_if bus_if ();

  uart_tx_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .len_i      (len_i),
    .abort_i    (abort_i),
    .buf_we_i   (buf_we_i),
    .buf_addr_i (buf_addr_i),
    .buf_data_i (buf_data_i),
    .io         (bus_if),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .sent_cnt_o (sent_cnt_o)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int hold_cycles = 0;
  int uart_busy = 0;
  int busy_viol = 0;
  logic wr_pend = 1'b0;
  logic [31:0] wr_data_q [$];
  int wr_cyc_q [$];
  int done_q [$];
  logic [7:0] msg [10] = '{8'h32, 8'h30, 8'h32, 8'h33, 8'h32, 8'h31, 8'h31, 8'h30, 8'h31, 8'h33};

  always #5 clk = ~clk;

  // UART model: status bit0 stays high for hold_cycles cycles after each TX write.
  assign bus_if.bus_rdata = RD_HI | {31'd0, uart_busy != 0};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_pend) uart_busy <= hold_cycles;
    else if (uart_busy > 0) uart_busy <= uart_busy - 1;
  end

  always @(negedge clk) begin
    wr_pend = bus_if.bus_req && bus_if.bus_we && (bus_if.bus_addr == TXDATA);
    if (wr_pend) begin
      wr_data_q.push_back(bus_if.bus_wdata);
      wr_cyc_q.push_back(cyc);
      if (uart_busy != 0) busy_viol++;
    end
    if (done_o) done_q.push_back(cyc);
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_q.delete();
    busy_viol = 0;
  endtask

  task automatic write_buf(input int a, input logic [7:0] d);
    buf_we_i   = 1'b1;
    buf_addr_i = a[3:0];
    buf_data_i = d;
    next();
    buf_we_i   = 1'b0;
  endtask

  task automatic load_msg();
    for (int i = 0; i < 10; i++) write_buf(i, msg[i]);
  endtask

  task automatic start_msg(input logic [4:0] len, output int t0);
    start_i = 1'b1;
    len_i   = len;
    t0      = cyc;
    next();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_q.size() > 0) break;
      next();
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    bus_if.cpu_req = 1'b1;
    #10;
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
    n_cmp++; if (bus_if.cpu_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b expected 0", bus_if.cpu_gnt); end
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_bus_req: got %b expected 0", bus_if.bus_req); end
    n_cmp++; if (sent_cnt_o !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_sent_cnt: got %0d expected 0", sent_cnt_o); end
    rst = 1'b1;
    bus_if.cpu_req = 1'b0;
    next();
  endtask

  task automatic test_message();
    int t0, d;
    clr();
    hold_cycles = 0;
    start_msg(5'd10, t0);
    wait_done(100);
    repeat (3) next();
    n_cmp++; if (wr_data_q.size() != 10) begin n_fail++; $display("[TB] FAIL msg_count: got %0d expected 10", wr_data_q.size()); end
    for (int k = 0; k < 10 && k < wr_data_q.size(); k++) begin
      n_cmp++; if (wr_data_q[k] !== {24'd0, msg[k]}) begin n_fail++; $display("[TB] FAIL msg_byte%0d: got %h expected %h", k, wr_data_q[k], msg[k]); end
      n_cmp++; if (wr_cyc_q[k] != t0 + 3*k + 2) begin n_fail++; $display("[TB] FAIL msg_cycle%0d: got t+%0d expected t+%0d", k, wr_cyc_q[k] - t0, 3*k + 2); end
    end
    d = (done_q.size() > 0) ? done_q[0] - t0 : -1;
    n_cmp++; if (done_q.size() != 1 || d != 30) begin n_fail++; $display("[TB] FAIL msg_done: got %0d pulses at t+%0d expected 1 at t+30", done_q.size(), d); end
    n_cmp++; if (sent_cnt_o !== 5'd10) begin n_fail++; $display("[TB] FAIL msg_sent_cnt: got %0d expected 10", sent_cnt_o); end
  endtask

  task automatic test_busy_uart();
    int t0, d;
    clr();
    hold_cycles = 5;
    start_msg(5'd10, t0);
    wait_done(200);
    repeat (3) next();
    n_cmp++; if (wr_data_q.size() != 10) begin n_fail++; $display("[TB] FAIL slow_count: got %0d expected 10", wr_data_q.size()); end
    for (int k = 0; k < 10 && k < wr_data_q.size(); k++) begin
      n_cmp++; if (wr_data_q[k] !== {24'd0, msg[k]}) begin n_fail++; $display("[TB] FAIL slow_byte%0d: got %h expected %h", k, wr_data_q[k], msg[k]); end
      n_cmp++; if (wr_cyc_q[k] != t0 + 7*k + 2) begin n_fail++; $display("[TB] FAIL slow_cycle%0d: got t+%0d expected t+%0d", k, wr_cyc_q[k] - t0, 7*k + 2); end
    end
    n_cmp++; if (busy_viol != 0) begin n_fail++; $display("[TB] FAIL slow_write_while_busy: got %0d expected 0", busy_viol); end
    d = (done_q.size() > 0) ? done_q[0] - t0 : -1;
    n_cmp++; if (done_q.size() != 1 || d != 66) begin n_fail++; $display("[TB] FAIL slow_done: got %0d pulses at t+%0d expected 1 at t+66", done_q.size(), d); end
    hold_cycles = 0;
    repeat (6) next();
  endtask

  task automatic test_cpu_block();
    int t0;
    int blk_err = 0;
    clr();
    start_i = 1'b1;
    len_i = 5'd3;
    bus_if.cpu_req = 1'b1;
    bus_if.cpu_we = 1'b0;
    bus_if.cpu_addr = STATUS;
    bus_if.cpu_wdata = 32'd0;
    t0 = cyc;
    #1;
    n_cmp++; if (bus_if.cpu_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL start_cpu_gnt: got %b expected 1", bus_if.cpu_gnt); end
    n_cmp++; if (bus_if.cpu_rdata !== RD_HI) begin n_fail++; $display("[TB] FAIL start_cpu_rdata: got %h expected %h", bus_if.cpu_rdata, RD_HI); end
    n_cmp++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b0 || bus_if.bus_addr !== STATUS) begin n_fail++; $display("[TB] FAIL start_cpu_bus: got req=%b we=%b addr=%h expected req=1 we=0 addr=%h", bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, STATUS); end
    next();
    start_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL poll_after_start: got busy %b expected 1", busy_o); end
    for (int i = 0; i < 50; i++) begin
      if (done_o === 1'b1) break;
      if (bus_if.cpu_gnt !== 1'b0 || bus_if.cpu_rdata !== 32'd0) blk_err++;
      next();
    end
    n_cmp++; if (blk_err != 0) begin n_fail++; $display("[TB] FAIL cpu_blocked: got %0d granted cycles expected 0", blk_err); end
    n_cmp++; if (done_o !== 1'b1 || cyc != t0 + 9) begin n_fail++; $display("[TB] FAIL cpu_done_cycle: got done=%b at t+%0d expected done=1 at t+9", done_o, cyc - t0); end
    n_cmp++; if (bus_if.cpu_gnt !== 1'b1 || bus_if.cpu_rdata !== RD_HI) begin n_fail++; $display("[TB] FAIL cpu_done_grant: got gnt=%b rdata=%h expected gnt=1 rdata=%h", bus_if.cpu_gnt, bus_if.cpu_rdata, RD_HI); end
    bus_if.cpu_req = 1'b0;
    repeat (2) next();
  endtask

  task automatic test_len_zero();
    int t0;
    clr();
    start_msg(5'd0, t0);
    n_cmp++; if (done_o !== 1'b1 || cyc != t0 + 1) begin n_fail++; $display("[TB] FAIL len0_done: got done=%b at t+%0d expected done=1 at t+1", done_o, cyc - t0); end
    n_cmp++; if (bus_if.bus_req !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL len0_idle_bus: got req=%b busy=%b expected 0 0", bus_if.bus_req, busy_o); end
    next();
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL len0_pulse: got %b expected 0", done_o); end
    n_cmp++; if (wr_data_q.size() != 0) begin n_fail++; $display("[TB] FAIL len0_writes: got %0d expected 0", wr_data_q.size()); end
  endtask

  task automatic test_len_sat();
    int t0, d;
    for (int i = 0; i < 16; i++) write_buf(i, 8'h40 + 8'(i));
    clr();
    start_msg(5'd20, t0);
    wait_done(100);
    repeat (2) next();
    n_cmp++; if (wr_data_q.size() != 16) begin n_fail++; $display("[TB] FAIL sat_count: got %0d expected 16", wr_data_q.size()); end
    for (int k = 0; k < 16 && k < wr_data_q.size(); k++) begin
      n_cmp++; if (wr_data_q[k] !== 32'h40 + 32'(k)) begin n_fail++; $display("[TB] FAIL sat_byte%0d: got %h expected %h", k, wr_data_q[k], 32'h40 + 32'(k)); end
    end
    d = (done_q.size() > 0) ? done_q[0] - t0 : -1;
    n_cmp++; if (d != 48) begin n_fail++; $display("[TB] FAIL sat_done: got t+%0d expected t+48", d); end
    n_cmp++; if (sent_cnt_o !== 5'd16) begin n_fail++; $display("[TB] FAIL sat_sent_cnt: got %0d expected 16", sent_cnt_o); end
  endtask

  task automatic test_abort();
    int t0, t1;
    load_msg();
    clr();
    start_msg(5'd10, t0);
    for (int i = 0; i < 20 && cyc < t0 + 9; i++) next();
    abort_i = 1'b1;
    n_cmp++; if (busy_o !== 1'b1 || wr_data_q.size() != 3) begin n_fail++; $display("[TB] FAIL abort_in_hold: got busy=%b writes=%0d expected 1 3", busy_o, wr_data_q.size()); end
    next();
    abort_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_idle: got busy=%b done=%b expected 0 0", busy_o, done_o); end
    n_cmp++; if (sent_cnt_o !== 5'd3) begin n_fail++; $display("[TB] FAIL abort_sent_cnt: got %0d expected 3", sent_cnt_o); end
    repeat (5) next();
    n_cmp++; if (done_q.size() != 0 || wr_data_q.size() != 3) begin n_fail++; $display("[TB] FAIL abort_quiet: got %0d done %0d writes expected 0 3", done_q.size(), wr_data_q.size()); end
    clr();
    start_msg(5'd2, t1);
    wait_done(30);
    next();
    n_cmp++; if (wr_data_q.size() != 2 || wr_data_q[0] !== 32'h32 || wr_data_q[1] !== 32'h30) begin n_fail++; $display("[TB] FAIL restart_from_0: got %0d writes first %h expected 2 writes 32 30", wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx); end
    n_cmp++; if (sent_cnt_o !== 5'd2) begin n_fail++; $display("[TB] FAIL restart_sent_cnt: got %0d expected 2", sent_cnt_o); end
  endtask

  task automatic test_reset_mid();
    int t0, t1;
    clr();
    hold_cycles = 20;
    start_msg(5'd10, t0);
    buf_we_i = 1'b1;
    buf_addr_i = 4'd0;
    buf_data_i = 8'hEE;
    next();
    buf_we_i = 1'b0;
    repeat (2) next();
    bus_if.cpu_req = 1'b1;
    bus_if.cpu_we = 1'b0;
    bus_if.cpu_addr = STATUS;
    #1;
    n_cmp++; if (busy_o !== 1'b1 || bus_if.cpu_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL pre_reset_poll: got busy=%b gnt=%b expected 1 0", busy_o, bus_if.cpu_gnt); end
    rst = 1'b0;
    #1;
    n_cmp++; if (busy_o !== 1'b0 || done_o !== 1'b0 || bus_if.cpu_gnt !== 1'b0 || bus_if.bus_req !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset: got busy=%b done=%b gnt=%b req=%b expected all 0", busy_o, done_o, bus_if.cpu_gnt, bus_if.bus_req); end
    next();
    rst = 1'b1;
    hold_cycles = 0;
    bus_if.cpu_we = 1'b1;
    bus_if.cpu_addr = 32'h3000_0010;
    bus_if.cpu_wdata = 32'h0000_0055;
    #1;
    n_cmp++; if (bus_if.cpu_gnt !== 1'b1 || bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b1 || bus_if.bus_addr !== 32'h3000_0010 || bus_if.bus_wdata !== 32'h55) begin n_fail++; $display("[TB] FAIL post_reset_pass: got gnt=%b req=%b we=%b addr=%h wdata=%h expected 1 1 1 30000010 00000055", bus_if.cpu_gnt, bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata); end
    next();
    bus_if.cpu_req = 1'b0;
    bus_if.cpu_we = 1'b0;
    repeat (25) next();
    clr();
    start_msg(5'd1, t1);
    wait_done(30);
    next();
    n_cmp++; if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'h32) begin n_fail++; $display("[TB] FAIL buf_locked: got %0d writes first %h expected 1 write 00000032", wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx); end
  endtask

  initial begin
    bus_if.cpu_req = 1'b0;
    bus_if.cpu_we = 1'b0;
    bus_if.cpu_addr = 32'd0;
    bus_if.cpu_wdata = 32'd0;
    test_reset();
    load_msg();
    test_message();
    test_busy_uart();
    test_cpu_block();
    test_len_zero();
    test_len_sat();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
